// File: rtl/pixel_stage_sequencer_pkg.sv
// Shared frame-buffer widths, sequencer state encoding and counter sizes
// for the pixel stage sequencer and its bus mux.
package pixel_stage_sequencer_pkg;

  localparam int unsigned FB_ADDR_W = 18;
  localparam int unsigned FB_DATA_W = 32;
  localparam int unsigned TIMER_W   = 20;
  // Stage index must also represent NUM_STAGES itself (up to 8) as the end marker.
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_ENABLE    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/pixel_stage_sequencer_fb_bus_mux.sv
// Combinational select of one stage's RAM bus onto the shared frame-buffer
// port; write enable is suppressed while that stage reports done.
module pixel_stage_sequencer_fb_bus_mux
  import pixel_stage_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned DATA_W     = FB_DATA_W
) (
  input  logic                         sel_valid,
  input  logic [IDX_W-1:0]             sel_idx,
  input  logic                         wren_block,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
  input  logic [NUM_STAGES-1:0]        stage_wren,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data_write,
  output logic [ADDR_W-1:0]            ram_address_c,
  output logic                         ram_wren_c,
  output logic [DATA_W-1:0]            ram_data_write_c
);

  always_comb begin
    ram_address_c    = '0;
    ram_wren_c       = 1'b0;
    ram_data_write_c = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (sel_valid && (sel_idx == IDX_W'(i))) begin
        ram_address_c    = stage_address[i*ADDR_W +: ADDR_W];
        ram_wren_c       = stage_wren[i] & ~wren_block;
        ram_data_write_c = stage_data_write[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/pixel_stage_sequencer.sv
// Runs the unmasked image-processing stages in index order over the
// enable/done handshake and routes the active stage onto the frame buffer.
module pixel_stage_sequencer
  import pixel_stage_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned ADDR_W         = FB_ADDR_W,
  parameter int unsigned DATA_W         = FB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 600000
) (
  input  logic                         clk_div_by_two,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_STAGES-1:0]        stage_mask,
  input  logic [NUM_STAGES-1:0]        done_stage,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
  input  logic [NUM_STAGES-1:0]        stage_wren,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data_write,
  output logic [NUM_STAGES-1:0]        enable_stage,
  output logic [ADDR_W-1:0]            ram_address,
  output logic                         ram_wren,
  output logic [DATA_W-1:0]            ram_data_write,
  output logic                         busy,
  output logic                         sequence_done,
  output logic                         timeout_error,
  output logic [2:0]                   active_stage
);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  mask_q, mask_d;
  logic [NUM_STAGES-1:0]  enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   seq_done_q, seq_done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   abort_seen_q, abort_seen_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;

  logic done_cur_c, en_cur_c, mask_cur_c, idx_end_c, timer_hit_c, mux_sel_c;

  // Per-index views; an index past the last stage reads as idle.
  always_comb begin
    done_cur_c = 1'b0;
    en_cur_c   = 1'b0;
    mask_cur_c = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        done_cur_c = done_stage[i];
        en_cur_c   = enable_q[i];
        mask_cur_c = mask_q[i];
      end
    end
  end

  assign idx_end_c   = (idx_q == IDX_W'(NUM_STAGES));
  assign timer_hit_c = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_div_by_two or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      mask_q        <= '0;
      enable_q      <= '0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      abort_seen_q  <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      mask_q        <= mask_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
      abort_seen_q  <= abort_seen_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    enable_d      = enable_q;
    busy_d        = busy_q;
    seq_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    abort_seen_d  = abort_seen_q;
    timer_d       = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d        = stage_mask;
          idx_d         = '0;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          abort_seen_d  = 1'b0;
          state_d       = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (idx_end_c) begin
          state_d = ST_FINISH;
        end else if (!mask_cur_c) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        // Hold off while the stage still shows done from a previous pass.
        if (!done_cur_c) begin
          enable_d = NUM_STAGES'(1) << idx_q;
          timer_d  = '0;
          state_d  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_cur_c) begin
          enable_d = '0;
          state_d  = ST_RELEASE;
        end else if (timer_hit_c) begin
          enable_d      = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_RELEASE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!done_cur_c) begin
          if (timeout_err_q || abort_seen_q) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SELECT;
          end
        end
      end
      ST_FINISH: begin
        busy_d     = 1'b0;
        seq_done_d = ~timeout_err_q & ~abort_seen_q & ~abort;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort parks in RELEASE so the current stage can drop its done first.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
      enable_d     = '0;
      abort_seen_d = 1'b1;
      idx_d        = idx_q;
      state_d      = ST_RELEASE;
    end
  end

  assign mux_sel_c = (state_q == ST_WAIT_DONE) || en_cur_c;

  pixel_stage_sequencer_fb_bus_mux #(
    .NUM_STAGES (NUM_STAGES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) u_fb_bus_mux (
    .sel_valid        (mux_sel_c),
    .sel_idx          (idx_q),
    .wren_block       (done_cur_c),
    .stage_address    (stage_address),
    .stage_wren       (stage_wren),
    .stage_data_write (stage_data_write),
    .ram_address_c    (ram_address),
    .ram_wren_c       (ram_wren),
    .ram_data_write_c (ram_data_write)
  );

  assign enable_stage  = enable_q;
  assign busy          = busy_q;
  assign sequence_done = seq_done_q;
  assign timeout_error = timeout_err_q;
  assign active_stage  = 3'(idx_q);

endmodule

// File: tb/tb_pixel_stage_sequencer.sv
// Directed bench for pixel_stage_sequencer: stub stages answer enable with
// done after a programmable delay; checks handshake order, mux, timeout, abort, reset.
module tb_pixel_stage_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 50;

  logic              clk_div_by_two = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [NS-1:0]     stage_mask;
  logic [NS-1:0]     done_stage;
  logic [NS*AW-1:0]  stage_address;
  logic [NS-1:0]     stage_wren;
  logic [NS*DW-1:0]  stage_data_write;
  logic [NS-1:0]     enable_stage;
  logic [AW-1:0]     ram_address;
  logic              ram_wren;
  logic [DW-1:0]     ram_data_write;
  logic              busy;
  logic              sequence_done;
  logic              timeout_error;
  logic [2:0]        active_stage;

  pixel_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_div_by_two   (clk_div_by_two),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .stage_mask       (stage_mask),
    .done_stage       (done_stage),
    .stage_address    (stage_address),
    .stage_wren       (stage_wren),
    .stage_data_write (stage_data_write),
    .enable_stage     (enable_stage),
    .ram_address      (ram_address),
    .ram_wren         (ram_wren),
    .ram_data_write   (ram_data_write),
    .busy             (busy),
    .sequence_done    (sequence_done),
    .timeout_error    (timeout_error),
    .active_stage     (active_stage)
  );

  initial forever #5 clk_div_by_two = ~clk_div_by_two;

  // Stub stages: done rises dly edges after enable, clears once enable is low.
  logic [NS-1:0] stub_done;
  logic [NS-1:0] hang;
  logic [NS-1:0] force_done;
  int            stub_cnt [NS];
  int            dly;

  always @(posedge clk_div_by_two) begin
    for (int i = 0; i < NS; i++) begin
      if (!enable_stage[i]) begin
        stub_cnt[i]  <= 0;
        stub_done[i] <= 1'b0;
      end else if (!hang[i] && !stub_done[i]) begin
        if (stub_cnt[i] == dly - 1) stub_done[i] <= 1'b1;
        else stub_cnt[i] <= stub_cnt[i] + 1;
      end
    end
  end

  assign done_stage = stub_done | force_done;

  // Running tallies sampled on the falling edge.
  int busy_cyc;
  int done_cnt;
  int overlap_cnt;
  int en_cyc [NS];

  always @(negedge clk_div_by_two) begin
    busy_cyc <= busy_cyc + int'(busy);
    done_cnt <= done_cnt + int'(sequence_done);
    if ($countones(enable_stage) > 1) overlap_cnt <= overlap_cnt + 1;
    for (int i = 0; i < NS; i++) en_cyc[i] <= en_cyc[i] + int'(enable_stage[i]);
  end

  int s_busy, s_done, s_ovl;
  int s_en [NS];

  task automatic snap();
    s_busy = busy_cyc;
    s_done = done_cnt;
    s_ovl  = overlap_cnt;
    for (int i = 0; i < NS; i++) s_en[i] = en_cyc[i];
  endtask

  int total;
  int bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_div_by_two);
    #1;
  endtask

  task automatic pulse_start(input logic [NS-1:0] m);
    stage_mask = m;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  task automatic wait_enable(input int i, input int budget, input string tag);
    for (int k = 0; k < budget && enable_stage[i] !== 1'b1; k++) cyc(1);
    chk(tag, 64'(enable_stage[i]), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int k = 0; k < budget && busy !== 1'b0; k++) cyc(1);
    chk(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    total = 0;
    bad   = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; stage_mask = '0;
    hang = '0; force_done = '0; dly = 10;
    stage_address = '0; stage_wren = '0; stage_data_write = '0;
    cyc(3);

    // Reset state
    chk("rst_enable", 64'(enable_stage), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_seq_done", 64'(sequence_done), 64'd0);
    chk("rst_timeout", 64'(timeout_error), 64'd0);
    chk("rst_active", 64'(active_stage), 64'd0);
    chk("rst_ram_wren", 64'(ram_wren), 64'd0);
    chk("rst_ram_addr", 64'(ram_address), 64'd0);
    reset_n = 1'b1;
    cyc(2);

    // Mask 0101: stage 0 then stage 2, 2*dly+14 busy cycles
    snap();
    pulse_start(4'b0101);
    chk("t1_busy_rise", 64'(busy), 64'd1);
    wait_enable(2, 100, "t1_en2_seen");
    chk("t1_active2", 64'(active_stage), 64'd2);
    wait_idle(200, "t1_idle");
    chk("t1_done_pulse", 64'(sequence_done), 64'd1);
    cyc(1);
    chk("t1_done_once", 64'(sequence_done), 64'd0);
    chk("t1_busy_span", 64'(busy_cyc - s_busy), 64'(2 * dly + 14));
    chk("t1_done_cnt", 64'(done_cnt - s_done), 64'd1);
    chk("t1_en0_cyc", 64'(en_cyc[0] - s_en[0]), 64'(dly + 1));
    chk("t1_en1_cyc", 64'(en_cyc[1] - s_en[1]), 64'd0);
    chk("t1_en2_cyc", 64'(en_cyc[2] - s_en[2]), 64'(dly + 1));
    chk("t1_en3_cyc", 64'(en_cyc[3] - s_en[3]), 64'd0);
    chk("t1_overlap", 64'(overlap_cnt - s_ovl), 64'd0);

    // Bus mux: stage 1 routed, stage 0 ignored, wren gated while done
    stage_address[0 +: AW]  = 18'd77;
    stage_wren[0]           = 1'b1;
    stage_data_write[0 +: DW] = 32'hdead;
    stage_address[AW +: AW] = 18'd2240;
    stage_wren[1]           = 1'b1;
    stage_data_write[DW +: DW] = 32'd1;
    #1;
    chk("t2_idle_wren", 64'(ram_wren), 64'd0);
    chk("t2_idle_addr", 64'(ram_address), 64'd0);
    cyc(1);
    pulse_start(4'b0010);
    wait_enable(1, 20, "t2_en1_seen");
    chk("t2_addr", 64'(ram_address), 64'd2240);
    chk("t2_wren", 64'(ram_wren), 64'd1);
    chk("t2_data", 64'(ram_data_write), 64'd1);
    #2;
    stage_address[AW +: AW] = 18'd2560;
    #1;
    chk("t2_addr_comb", 64'(ram_address), 64'd2560);
    cyc(1);
    for (k = 0; k < 30 && done_stage[1] !== 1'b1; k++) cyc(1);
    chk("t2_done_seen", 64'(done_stage[1]), 64'd1);
    chk("t2_overlap_en", 64'(enable_stage), 64'd2);
    chk("t2_wren_gated", 64'(ram_wren), 64'd0);
    chk("t2_addr_held", 64'(ram_address), 64'd2560);
    wait_idle(50, "t2_idle");
    stage_address = '0; stage_wren = '0; stage_data_write = '0;
    cyc(2);

    // Stage 1 hangs: timeout after TO cycles, stage 2 never enabled
    hang = 4'b0010;
    snap();
    pulse_start(4'b0111);
    wait_idle(300, "t3_idle");
    chk("t3_no_done", 64'(sequence_done), 64'd0);
    chk("t3_timeout", 64'(timeout_error), 64'd1);
    chk("t3_en0_cyc", 64'(en_cyc[0] - s_en[0]), 64'(dly + 1));
    chk("t3_en1_cyc", 64'(en_cyc[1] - s_en[1]), 64'(TO));
    chk("t3_en2_cyc", 64'(en_cyc[2] - s_en[2]), 64'd0);
    chk("t3_done_cnt", 64'(done_cnt - s_done), 64'd0);
    hang = '0;
    cyc(3);
    chk("t3_sticky", 64'(timeout_error), 64'd1);
    pulse_start(4'b0000);
    chk("t3_cleared", 64'(timeout_error), 64'd0);
    wait_idle(20, "t3_idle2");
    cyc(2);

    // Abort 10 cycles into stage 0, then a normal run
    dly = 30;
    snap();
    pulse_start(4'b0011);
    wait_enable(0, 20, "t4_en0_seen");
    cyc(9);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("t4_abort_drop", 64'(enable_stage), 64'd0);
    wait_idle(20, "t4_idle");
    chk("t4_no_done", 64'(sequence_done), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt - s_done), 64'd0);
    chk("t4_en0_cyc", 64'(en_cyc[0] - s_en[0]), 64'd10);
    chk("t4_en1_cyc", 64'(en_cyc[1] - s_en[1]), 64'd0);
    cyc(2);
    snap();
    pulse_start(4'b0011);
    wait_idle(200, "t4_rerun_idle");
    chk("t4_rerun_done", 64'(sequence_done), 64'd1);
    chk("t4_rerun_en0", 64'(en_cyc[0] - s_en[0]), 64'(dly + 1));
    chk("t4_rerun_en1", 64'(en_cyc[1] - s_en[1]), 64'(dly + 1));
    cyc(2);

    // Stale done holds the stage off until it clears
    dly = 10;
    force_done = 4'b0001;
    pulse_start(4'b0001);
    cyc(5);
    chk("stale_hold_en", 64'(enable_stage), 64'd0);
    chk("stale_hold_busy", 64'(busy), 64'd1);
    force_done = '0;
    cyc(1);
    chk("stale_release_en", 64'(enable_stage), 64'd1);
    wait_idle(50, "stale_idle");
    cyc(2);

    // Async reset mid WAIT_DONE
    dly = 30;
    stage_wren[0] = 1'b1;
    pulse_start(4'b0001);
    wait_enable(0, 20, "t5_en0_seen");
    cyc(3);
    chk("t5_pre_wren", 64'(ram_wren), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_enable", 64'(enable_stage), 64'd0);
    chk("t5_rst_wren", 64'(ram_wren), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_active", 64'(active_stage), 64'd0);
    cyc(2);
    reset_n = 1'b1;
    stage_wren = '0;
    cyc(1);
    chk("t5_post_busy", 64'(busy), 64'd0);
    chk("t5_post_enable", 64'(enable_stage), 64'd0);
    pulse_start(4'b0001);
    wait_idle(100, "t5_run_idle");
    chk("t5_run_done", 64'(sequence_done), 64'd1);
    cyc(2);

    // Mask 0: done pulse NUM_STAGES+2 edges after start; start while busy ignored
    snap();
    pulse_start(4'b0000);
    for (k = 1; k <= 20; k++) begin
      cyc(1);
      if (sequence_done === 1'b1) break;
      if (k == 2) begin stage_mask = 4'b1111; start = 1'b1; end
      if (k == 3) start = 1'b0;
    end
    start = 1'b0;
    chk("t6_latency", 64'(k), 64'(NS + 2));
    chk("t6_busy_low", 64'(busy), 64'd0);
    cyc(20);
    chk("t6_no_enable", 64'((en_cyc[0] - s_en[0]) + (en_cyc[1] - s_en[1]) +
                            (en_cyc[2] - s_en[2]) + (en_cyc[3] - s_en[3])), 64'd0);
    chk("t6_done_cnt", 64'(done_cnt - s_done), 64'd1);
    chk("t6_still_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
